seq_muldiv: RTL and testbench

SEQ_MULDIV -- requirements
Module: seq_muldiv

---
 rtl/seq_muldiv.sv | 162 ++++++++++++++++
 tb/tb_seq_muldiv.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seq_muldiv.sv
// rtl/seq_muldiv.sv - sequential radix-2 multiplier and restoring divider
// Division datapath is present only when SEQ_MULDIV_DIV_EN is defined.
module seq_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero,
    output logic             unsupported
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   a_abs_q, a_abs_d, b_abs_q, b_abs_d;
    logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               dz_q, dz_d, unsup_q, unsup_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] product;

    // acc holds {partial product (WIDTH+1), remaining multiplier bits (WIDTH)}
    assign mul_sum = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, a_abs_q} : {(WIDTH+1){1'b0}});
    assign product = (sign_a_q ^ sign_b_q) ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];

`ifdef SEQ_MULDIV_DIV_EN
    logic               is_div_q, is_div_d;
    logic [WIDTH:0]     div_shift, div_trial;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // For divide acc holds {remainder (WIDTH+1), dividend/quotient (WIDTH)}
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, b_abs_q};
    assign quo_fix   = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix   = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        a_abs_d  = a_abs_q;
        b_abs_d  = b_abs_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        dz_d     = dz_q;
        unsup_d  = unsup_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
`ifdef SEQ_MULDIV_DIV_EN
        is_div_d = is_div_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                dz_d     = 1'b0;
                unsup_d  = 1'b0;
                cnt_d    = '0;
                sign_a_d = ~op[0] & src_a[WIDTH-1];
                sign_b_d = ~op[0] & src_b[WIDTH-1];
                a_abs_d  = sign_a_d ? -src_a : src_a;
                b_abs_d  = sign_b_d ? -src_b : src_b;
                state_d  = RUN;
`ifdef SEQ_MULDIV_DIV_EN
                is_div_d = op[1];
                acc_d    = {{(WIDTH+1){1'b0}}, (op[1] ? a_abs_d : b_abs_d)};
                if (op[1] && (src_b == '0)) begin
                    dz_d    = 1'b1;
                    state_d = DONE;
                end
`else
                acc_d    = {{(WIDTH+1){1'b0}}, b_abs_d};
                if (op[1]) begin
                    unsup_d = 1'b1;
                    state_d = DONE;
                end
`endif
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                acc_d = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
`ifdef SEQ_MULDIV_DIV_EN
                if (is_div_q) begin
                    acc_d = div_trial[WIDTH] ? {div_shift, acc_q[WIDTH-2:0], 1'b0}
                                             : {div_trial, acc_q[WIDTH-2:0], 1'b1};
                end
`endif
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                state_d    = DONE;
                {hi_d, lo_d} = product;
`ifdef SEQ_MULDIV_DIV_EN
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            a_abs_q  <= '0;
            b_abs_q  <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            unsup_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef SEQ_MULDIV_DIV_EN
            is_div_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            a_abs_q  <= a_abs_d;
            b_abs_q  <= b_abs_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
            unsup_q  <= unsup_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
`ifdef SEQ_MULDIV_DIV_EN
            is_div_q <= is_div_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_zero    = dz_q;
    assign unsupported = unsup_q;
endmodule

// File: tb/tb_seq_muldiv.sv
// tb/tb_seq_muldiv.sv - scoreboard bench for seq_muldiv at WIDTH=32 and WIDTH=8
module tb_seq_muldiv;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    logic        start32 = 1'b0, start8 = 1'b0;
    logic [1:0]  op32 = 2'b00, op8 = 2'b00;
    logic [31:0] a32 = '0, b32 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy32, done32, dz32, un32, busy8, done8, dz8, un8;
    logic [31:0] hi32, lo32;
    logic [7:0]  hi8, lo8;
    logic        done32_prev = 1'b0, done8_prev = 1'b0;

    typedef struct {
        logic [63:0] hi;
        logic [63:0] lo;
        logic        dz;
        logic        un;
        int          due;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];

    seq_muldiv #(.WIDTH(32)) u32 (
        .clk(clk), .reset(rst_n), .start(start32), .op(op32), .src_a(a32), .src_b(b32),
        .busy(busy32), .done(done32), .hi(hi32), .lo(lo32), .div_zero(dz32), .unsupported(un32)
    );

    seq_muldiv #(.WIDTH(8)) u8 (
        .clk(clk), .reset(rst_n), .start(start8), .op(op8), .src_a(a8), .src_b(b8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_zero(dz8), .unsupported(un8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done32) begin
            exp_t e;
            chk("done_one_cycle32", {63'd0, done32_prev}, 64'd0);
            if (q32.size() == 0) begin
                chk("unexpected_done32", 64'd1, 64'd0);
            end else begin
                e = q32.pop_front();
                chk("hi32", {32'd0, hi32}, e.hi);
                chk("lo32", {32'd0, lo32}, e.lo);
                chk("div_zero32", {63'd0, dz32}, {63'd0, e.dz});
                chk("unsupported32", {63'd0, un32}, {63'd0, e.un});
                chk("latency32", 64'(cyc), 64'(e.due));
            end
        end
        done32_prev <= done32;
    end

    always @(negedge clk) begin
        if (rst_n && done8) begin
            exp_t e;
            chk("done_one_cycle8", {63'd0, done8_prev}, 64'd0);
            if (q8.size() == 0) begin
                chk("unexpected_done8", 64'd1, 64'd0);
            end else begin
                e = q8.pop_front();
                chk("hi8", {56'd0, hi8}, e.hi);
                chk("lo8", {56'd0, lo8}, e.lo);
                chk("div_zero8", {63'd0, dz8}, {63'd0, e.dz});
                chk("unsupported8", {63'd0, un8}, {63'd0, e.un});
                chk("latency8", 64'(cyc), 64'(e.due));
            end
        end
        done8_prev <= done8;
    end

    // Caller is at a negedge; returns at the negedge after done (or right after start if no_wait)
    task automatic run(input bit w8, input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                       input bit push, input logic [63:0] eh, input logic [63:0] el,
                       input bit dz, input bit un, input int lat, input bit no_wait);
        exp_t e;
        bit   seen;
        e.hi = eh; e.lo = el; e.dz = dz; e.un = un; e.due = cyc + lat;
        if (push) begin
            if (w8) q8.push_back(e);
            else    q32.push_back(e);
        end
        if (w8) begin
            op8 = o; a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
        end else begin
            op32 = o; a32 = a[31:0]; b32 = b[31:0]; start32 = 1'b1;
        end
        @(negedge clk);
        start8 = 1'b0; start32 = 1'b0;
        a8 = 8'h5A; b8 = 8'hC3; a32 = 32'hA5A5_5A5A; b32 = 32'h3C3C_C3C3;
        if (no_wait) return;
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if ((w8 && done8) || (!w8 && done32)) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) chk("done_timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("reset_busy", {62'd0, busy32, busy8}, 64'd0);
        chk("reset_done", {62'd0, done32, done8}, 64'd0);
        chk("reset_hilo32", {hi32, lo32}, 64'd0);
        chk("reset_flags", {60'd0, dz32, un32, dz8, un8}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // multiply on 32-bit
        run(0, 2'b00, 64'hFFFFFFFD, 64'h7, 1, 64'hFFFFFFFF, 64'hFFFFFFEB, 0, 0, 34, 0);
        run(0, 2'b01, 64'hFFFFFFFF, 64'hFFFFFFFF, 1, 64'hFFFFFFFE, 64'h1, 0, 0, 34, 0);
        run(0, 2'b00, 64'hFFFFFFFB, 64'hFFFFFFFD, 1, 64'h0, 64'hF, 0, 0, 34, 0);
        run(0, 2'b01, 64'h12345678, 64'h10, 1, 64'h1, 64'h23456780, 0, 0, 34, 0);

        // multiply on 8-bit
        run(1, 2'b00, 64'h80, 64'hFF, 1, 64'h00, 64'h80, 0, 0, 10, 0);
        run(1, 2'b01, 64'hFF, 64'hFF, 1, 64'hFE, 64'h01, 0, 0, 10, 0);

`ifdef SEQ_MULDIV_DIV_EN
        run(0, 2'b10, 64'hFFFFFFF9, 64'h2, 1, 64'hFFFFFFFF, 64'hFFFFFFFD, 0, 0, 34, 0);
        run(0, 2'b11, 64'd100, 64'd7, 1, 64'd2, 64'd14, 0, 0, 34, 0);
        run(0, 2'b11, 64'd100, 64'd0, 1, 64'd2, 64'd14, 1, 0, 1, 0);
        repeat (3) @(negedge clk);
        chk("div_zero_sticky", {63'd0, dz32}, 64'd1);
        run(0, 2'b10, 64'h7, 64'hFFFFFFFE, 1, 64'h1, 64'hFFFFFFFD, 0, 0, 34, 0);
        run(0, 2'b10, 64'h80000000, 64'hFFFFFFFF, 1, 64'h0, 64'h80000000, 0, 0, 34, 0);
        run(1, 2'b10, 64'h80, 64'hFF, 1, 64'h00, 64'h80, 0, 0, 10, 0);
`else
        run(0, 2'b11, 64'd10, 64'd3, 1, 64'h1, 64'h23456780, 0, 1, 1, 0);
        repeat (3) @(negedge clk);
        chk("unsupported_sticky", {63'd0, un32}, 64'd1);
        run(0, 2'b00, 64'd3, 64'd4, 1, 64'h0, 64'd12, 0, 0, 34, 0);
        run(1, 2'b10, 64'h80, 64'hFF, 1, 64'hFE, 64'h01, 0, 1, 1, 0);
`endif

        // second start mid-RUN must be ignored
        run(0, 2'b01, 64'd6, 64'd7, 1, 64'h0, 64'd42, 0, 0, 34, 1);
        repeat (5) @(negedge clk);
        op32 = 2'b01; a32 = 32'd100; b32 = 32'd100; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        for (int k = 0; k < 60 && q32.size() != 0; k++) @(negedge clk);
        chk("restart_drained", 64'(q32.size()), 64'd0);
        repeat (40) @(negedge clk);

        // reset mid-RUN discards the operation
        run(0, 2'b01, 64'd3, 64'd3, 0, 64'h0, 64'h0, 0, 0, 0, 1);
        repeat (10) @(negedge clk);
        chk("busy_before_reset", {63'd0, busy32}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_busy", {63'd0, busy32}, 64'd0);
        chk("reset_mid_hilo", {hi32, lo32}, 64'd0);
        chk("reset_mid_flags", {62'd0, dz32, un32}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (45) @(negedge clk);
        chk("no_done_after_reset", {62'd0, done32_prev, busy32}, 64'd0);

        run(0, 2'b00, 64'hFFFFFFFF, 64'hFFFFFFFF, 1, 64'h0, 64'h1, 0, 0, 34, 0);
        chk("queues_empty", 64'(q32.size() + q8.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
